// File: rtl/shared_pkg.sv
// Shared constants for the resource-shared adder: operand-pair select codes and default width.
package shared_pkg;

   localparam int unsigned DEF_W = 1;
   localparam int unsigned MAX_W = 32;

   localparam logic SEL_AB = 1'b0;
   localparam logic SEL_CD = 1'b1;

endpackage : shared_pkg

// File: rtl/shared_adder.sv
// Purely combinational W-bit unsigned adder with carry-out.
module shared_adder
   import shared_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] sum,
   output logic         carry
);

   localparam int unsigned SW = W + 1;

   logic [SW-1:0] full;

   // Zero-extend both operands so the carry lands in the top bit.
   always_comb begin
      full  = SW'({1'b0, x}) + SW'({1'b0, y});
      sum   = full[W-1:0];
      carry = full[W];
   end

endmodule : shared_adder

// File: rtl/shared.sv
// Resource-shared adder: one adder fed by an operand-pair mux, with a registered sum and valid.
module shared
   import shared_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   input  logic         m,
   input  logic         in_valid,
   output logic         s1,
   output logic [W-1:0] s0,
   output logic         out_valid
);

   logic [W-1:0] x_c;
   logic [W-1:0] y_c;
   logic [W-1:0] sum_c;
   logic         carry_c;

   // Operand pair select; the unselected pair never reaches the adder.
   always_comb begin
      x_c = a;
      y_c = b;
      if (m == SEL_CD) begin
         x_c = c;
         y_c = d;
      end
   end

   shared_adder #(
      .W(W)
   ) u_adder (
      .x    (x_c),
      .y    (y_c),
      .sum  (sum_c),
      .carry(carry_c)
   );

   // Result registers load only on an accepted sample; reset drops any concurrent input.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b0;
         s0        <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s1 <= carry_c;
            s0 <= sum_c;
         end
      end
   end

endmodule : shared

// File: tb/tb_shared.sv
// Directed, table-driven checks of the shared adder at W=1, plus a short W=8 sequence.
module tb_shared;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [0:0] a1, b1, c1, d1, s0_1;
   logic       m1, iv1, s1_1, ov1;

   logic [7:0] a8, b8, c8, d8, s0_8;
   logic       m8, iv8, s1_8, ov8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   shared #(.W(1)) dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .m(m1),
      .in_valid(iv1), .s1(s1_1), .s0(s0_1), .out_valid(ov1)
   );

   shared #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .m(m8),
      .in_valid(iv8), .s1(s1_8), .s0(s0_8), .out_valid(ov8)
   );

   typedef struct packed {
      logic rst;
      logic iv;
      logic m;
      logic a;
      logic b;
      logic c;
      logic d;
      logic s1;
      logic s0;
      logic ov;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check1(input string name, input logic es1, input logic es0, input logic eov);
      n_vec++;
      if (s1_1 !== es1 || s0_1 !== es0 || ov1 !== eov) begin
         n_err++;
         $display("FAIL %s: got s1=%b s0=%b ov=%b, want s1=%b s0=%b ov=%b",
                  name, s1_1, s0_1, ov1, es1, es0, eov);
      end
   endtask

   task automatic check8(input string name, input logic es1, input logic [7:0] es0, input logic eov);
      n_vec++;
      if (s1_8 !== es1 || s0_8 !== es0 || ov8 !== eov) begin
         n_err++;
         $display("FAIL %s: got s1=%b s0=%h ov=%b, want s1=%b s0=%h ov=%b",
                  name, s1_8, s0_8, ov8, es1, es0, eov);
      end
   endtask

   task automatic drive8(input logic r, input logic iv, input logic m,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
      @(negedge clk);
      rst = r; iv8 = iv; m8 = m; a8 = a; b8 = b; c8 = c; d8 = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            rst iv  m  a  b  c  d  s1 s0 ov
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0}; // reset
      vecs[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0}; // reset beats valid
      vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1}; // 0+1
      vecs[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1}; // cd 1+1
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1}; // ab 1+1
      vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1}; // cd 1+0
      vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1}; // ab 1+0
      vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1}; // cd 1+1, ab ignored
      vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1}; // ab 0+0, valid still high
      vecs[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1}; // cd 0+1
      vecs[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b1}; // ab 1+0
      vecs[11] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0}; // idle: hold
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0}; // idle: hold
      vecs[13] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1}; // ab 1+1
      vecs[14] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0}; // mid-stream reset
      vecs[15] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1}; // first after release
      vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0}; // idle: hold

      a1 = '0; b1 = '0; c1 = '0; d1 = '0; m1 = 1'b0; iv1 = 1'b0;
      a8 = '0; b8 = '0; c8 = '0; d8 = '0; m8 = 1'b0; iv8 = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst  = vecs[i].rst;
         iv1  = vecs[i].iv;
         m1   = vecs[i].m;
         a1   = vecs[i].a;
         b1   = vecs[i].b;
         c1   = vecs[i].c;
         d1   = vecs[i].d;
         @(posedge clk);
         #1;
         check1($sformatf("w1_vec%0d", i), vecs[i].s1, vecs[i].s0, vecs[i].ov);
      end

      // W=8: width-sensitive boundaries and pair isolation.
      drive8(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00);
      check8("w8_reset", 1'b0, 8'h00, 1'b0);
      drive8(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h01, 8'h02);
      check8("w8_ones", 1'b1, 8'hFE, 1'b1);
      drive8(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h80, 8'h7F);
      check8("w8_cd_nocarry", 1'b0, 8'hFF, 1'b1);
      drive8(1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'hFF, 8'hFF);
      check8("w8_ab", 1'b0, 8'h46, 1'b1);
      drive8(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'hA5, 8'h6B);
      check8("w8_cd_carry", 1'b1, 8'h10, 1'b1);
      drive8(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      check8("w8_hold", 1'b1, 8'h10, 1'b0);
      drive8(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF);
      check8("w8_zero", 1'b0, 8'h00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_shared
